// File: rtl/bcd_stopwatch_pkg.sv
// Shared types and BCD helpers for the stopwatch run/stop controller.
package bcd_stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    localparam logic [7:0] BCD_MAX = 8'h99;

    function automatic logic bcd_valid(input logic [7:0] value);
        return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9);
    endfunction

    // Two-digit BCD increment; 99 rolls over to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value[3:0] == 4'd9) begin
            result[3:0] = 4'd0;
            result[7:4] = (value[7:4] == 4'd9) ? 4'd0 : value[7:4] + 4'd1;
        end else begin
            result[7:4] = value[7:4];
            result[3:0] = value[3:0] + 4'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_ctrl_bcd_count2.sv
// Two-digit BCD counter with synchronous enable/clear and a registered wrap pulse.
module bcd_count2
    import bcd_stopwatch_pkg::*;
(
    input  logic       CK,
    input  logic       R,
    input  logic       en,
    input  logic       clr,
    output logic [7:0] q,
    output logic       wrap
);

    always_ff @(posedge CK or posedge R) begin
        if (R) begin
            q    <= 8'h00;
            wrap <= 1'b0;
        end else if (clr) begin
            q    <= 8'h00;
            wrap <= 1'b0;
        end else if (en) begin
            q    <= bcd_inc(q);
            wrap <= (q == BCD_MAX);
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch run/stop controller: command FSM, tick prescaler, lap capture and alarm compare.
//   state   | meaning
//   IDLE    | count held at 00, waiting for START
//   RUNNING | prescaler advancing, count steps on each tick
//   PAUSED  | count and prescaler phase frozen until START
module bcd_stopwatch_ctrl
    import bcd_stopwatch_pkg::*;
#(
    parameter int PRESCALE = 10
) (
    input  logic       CK,
    input  logic       R,
    input  logic       START,
    input  logic       STOP,
    input  logic       CLEAR,
    input  logic       LAP,
    input  logic       ALARM_LD,
    input  logic [7:0] ALARM_SET,
    output logic [7:0] Q,
    output logic [7:0] LAPQ,
    output logic       LAP_VALID,
    output logic       RUN,
    output logic       WRAP,
    output logic       ALARM,
    output logic       ERR
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    state_t        state;
    state_t        next_state;
    logic [PW-1:0] ps;
    logic [PW-1:0] ps_next;
    logic          tick;
    logic [7:0]    alarm_reg;
    logic          alarm_en;

    always_ff @(posedge CK or posedge R) begin
        if (R) state <= IDLE;
        else   state <= next_state;
    end

    // STOP outranks START, so a simultaneous pair never starts the count.
    always_comb begin
        next_state = state;
        ps_next    = ps;
        tick       = 1'b0;
        if (CLEAR) begin
            next_state = IDLE;
            ps_next    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START && !STOP) begin
                        next_state = RUNNING;
                        ps_next    = '0;
                    end
                end
                RUNNING: begin
                    if (STOP) begin
                        next_state = PAUSED;
                    end else if (ps == PS_LAST) begin
                        tick    = 1'b1;
                        ps_next = '0;
                    end else begin
                        ps_next = ps + PW'(1);
                    end
                end
                PAUSED: begin
                    if (START && !STOP) next_state = RUNNING;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge CK or posedge R) begin
        if (R) ps <= '0;
        else   ps <= ps_next;
    end

    bcd_count2 u_count (
        .CK   (CK),
        .R    (R),
        .en   (tick),
        .clr  (CLEAR),
        .q    (Q),
        .wrap (WRAP)
    );

    always_ff @(posedge CK or posedge R) begin
        if (R) begin
            LAPQ      <= 8'h00;
            LAP_VALID <= 1'b0;
        end else if (CLEAR) begin
            LAPQ      <= 8'h00;
            LAP_VALID <= 1'b0;
        end else if (LAP && (state != IDLE)) begin
            LAPQ      <= Q;
            LAP_VALID <= 1'b1;
        end else begin
            LAP_VALID <= 1'b0;
        end
    end

    always_ff @(posedge CK or posedge R) begin
        if (R) begin
            alarm_reg <= 8'h00;
            alarm_en  <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            ERR <= 1'b0;
            if (ALARM_LD) begin
                if (bcd_valid(ALARM_SET)) begin
                    alarm_reg <= ALARM_SET;
                    alarm_en  <= 1'b1;
                end else begin
                    ERR <= 1'b1;
                end
            end
        end
    end

    // Compare against the incremented value so ALARM lands with the matching Q.
    always_ff @(posedge CK or posedge R) begin
        if (R) ALARM <= 1'b0;
        else   ALARM <= tick && alarm_en && (bcd_inc(Q) == alarm_reg);
    end

    assign RUN = (state == RUNNING);

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for bcd_stopwatch_ctrl with PRESCALE=4.
module tb_bcd_stopwatch_ctrl;

    logic       CK;
    logic       R;
    logic       START;
    logic       STOP;
    logic       CLEAR;
    logic       LAP;
    logic       ALARM_LD;
    logic [7:0] ALARM_SET;
    logic [7:0] Q;
    logic [7:0] LAPQ;
    logic       LAP_VALID;
    logic       RUN;
    logic       WRAP;
    logic       ALARM;
    logic       ERR;

    int vectors;
    int miscompares;

    bcd_stopwatch_ctrl #(.PRESCALE(4)) dut (
        .CK        (CK),
        .R         (R),
        .START     (START),
        .STOP      (STOP),
        .CLEAR     (CLEAR),
        .LAP       (LAP),
        .ALARM_LD  (ALARM_LD),
        .ALARM_SET (ALARM_SET),
        .Q         (Q),
        .LAPQ      (LAPQ),
        .LAP_VALID (LAP_VALID),
        .RUN       (RUN),
        .WRAP      (WRAP),
        .ALARM     (ALARM),
        .ERR       (ERR)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic test_reset();
        step();
        vectors++;
        if (Q !== 8'h00) begin
            $display("FAIL reset_q: got %h want 00", Q); miscompares++;
        end
        vectors++;
        if (LAPQ !== 8'h00) begin
            $display("FAIL reset_lapq: got %h want 00", LAPQ); miscompares++;
        end
        vectors++;
        if ({RUN, WRAP, ALARM, ERR, LAP_VALID} !== 5'b0) begin
            $display("FAIL reset_flags: got %b want 00000", {RUN, WRAP, ALARM, ERR, LAP_VALID});
            miscompares++;
        end
        R = 1'b0;
        step();
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        vectors++;
        if (RUN !== 1'b0 || Q !== 8'h00) begin
            $display("FAIL idle_stop: got run=%b q=%h want 0/00", RUN, Q); miscompares++;
        end
    endtask

    task automatic test_start_latency();
        START = 1'b1;
        step();
        START = 1'b0;
        vectors++;
        if (RUN !== 1'b1 || Q !== 8'h00) begin
            $display("FAIL start_entry: got run=%b q=%h want 1/00", RUN, Q); miscompares++;
        end
        repeat (3) step();
        vectors++;
        if (Q !== 8'h00) begin
            $display("FAIL start_early: got %h want 00", Q); miscompares++;
        end
        step();
        vectors++;
        if (Q !== 8'h01) begin
            $display("FAIL start_first_tick: got %h want 01", Q); miscompares++;
        end
        repeat (3) step();
        vectors++;
        if (Q !== 8'h01) begin
            $display("FAIL start_between: got %h want 01", Q); miscompares++;
        end
        step();
        vectors++;
        if (Q !== 8'h02 || RUN !== 1'b1) begin
            $display("FAIL start_second_tick: got q=%h run=%b want 02/1", Q, RUN); miscompares++;
        end
        START = 1'b1;
        step();
        START = 1'b0;
        repeat (3) step();
        vectors++;
        if (Q !== 8'h03) begin
            $display("FAIL running_start_noop: got %h want 03", Q); miscompares++;
        end
    endtask

    task automatic test_pause_resume();
        CLEAR = 1'b1;
        step();
        CLEAR = 1'b0;
        START = 1'b1;
        step();
        START = 1'b0;
        repeat (4) step();
        vectors++;
        if (Q !== 8'h01) begin
            $display("FAIL pause_setup: got %h want 01", Q); miscompares++;
        end
        repeat (2) step();
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        vectors++;
        if (RUN !== 1'b0 || Q !== 8'h01) begin
            $display("FAIL pause_stop: got run=%b q=%h want 0/01", RUN, Q); miscompares++;
        end
        repeat (5) step();
        vectors++;
        if (Q !== 8'h01) begin
            $display("FAIL pause_frozen: got %h want 01", Q); miscompares++;
        end
        START = 1'b1;
        step();
        START = 1'b0;
        vectors++;
        if (RUN !== 1'b1 || Q !== 8'h01) begin
            $display("FAIL resume_entry: got run=%b q=%h want 1/01", RUN, Q); miscompares++;
        end
        step();
        vectors++;
        if (Q !== 8'h01) begin
            $display("FAIL resume_phase1: got %h want 01", Q); miscompares++;
        end
        step();
        vectors++;
        if (Q !== 8'h02) begin
            $display("FAIL resume_phase2: got %h want 02", Q); miscompares++;
        end
        repeat (3) step();
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        vectors++;
        if (Q !== 8'h02 || RUN !== 1'b0) begin
            $display("FAIL stop_on_tick: got q=%h run=%b want 02/0", Q, RUN); miscompares++;
        end
        START = 1'b1;
        step();
        START = 1'b0;
        vectors++;
        if (Q !== 8'h02) begin
            $display("FAIL stop_tick_resume: got %h want 02", Q); miscompares++;
        end
        step();
        vectors++;
        if (Q !== 8'h03) begin
            $display("FAIL stop_tick_first: got %h want 03", Q); miscompares++;
        end
    endtask

    task automatic test_wrap_alarm();
        int alarm_seen;
        alarm_seen = 0;
        CLEAR = 1'b1;
        step();
        CLEAR = 1'b0;
        ALARM_SET = 8'h05;
        ALARM_LD = 1'b1;
        step();
        ALARM_LD = 1'b0;
        vectors++;
        if (ERR !== 1'b0) begin
            $display("FAIL alarm_load_err: got %b want 0", ERR); miscompares++;
        end
        START = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i < 1000 && Q !== 8'h98; i++) begin
            step();
            if (ALARM === 1'b1) begin
                alarm_seen++;
                vectors++;
                if (Q !== 8'h05) begin
                    $display("FAIL alarm_value: got %h want 05", Q); miscompares++;
                end
            end
            if (WRAP === 1'b1) begin
                vectors++;
                $display("FAIL wrap_early: got WRAP at q=%h want none", Q); miscompares++;
            end
        end
        vectors++;
        if (Q !== 8'h98) begin
            $display("FAIL reach_98: got %h want 98", Q); miscompares++;
        end
        vectors++;
        if (alarm_seen != 1) begin
            $display("FAIL alarm_count: got %0d want 1", alarm_seen); miscompares++;
        end
        repeat (4) step();
        vectors++;
        if (Q !== 8'h99 || WRAP !== 1'b0) begin
            $display("FAIL wrap_99: got q=%h wrap=%b want 99/0", Q, WRAP); miscompares++;
        end
        repeat (3) step();
        vectors++;
        if (Q !== 8'h99 || WRAP !== 1'b0) begin
            $display("FAIL wrap_hold: got q=%h wrap=%b want 99/0", Q, WRAP); miscompares++;
        end
        step();
        vectors++;
        if (Q !== 8'h00 || WRAP !== 1'b1) begin
            $display("FAIL wrap_00: got q=%h wrap=%b want 00/1", Q, WRAP); miscompares++;
        end
        step();
        vectors++;
        if (WRAP !== 1'b0) begin
            $display("FAIL wrap_pulse: got %b want 0", WRAP); miscompares++;
        end
        for (int i = 0; i < 40 && ALARM !== 1'b1; i++) step();
        vectors++;
        if (ALARM !== 1'b1 || Q !== 8'h05) begin
            $display("FAIL alarm_second_pass: got alarm=%b q=%h want 1/05", ALARM, Q); miscompares++;
        end
    endtask

    task automatic test_lap_err();
        ALARM_SET = 8'h14;
        ALARM_LD = 1'b1;
        step();
        ALARM_LD = 1'b0;
        vectors++;
        if (ERR !== 1'b0) begin
            $display("FAIL alarm14_err: got %b want 0", ERR); miscompares++;
        end
        for (int i = 0; i < 60 && Q !== 8'h12; i++) step();
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        vectors++;
        if (Q !== 8'h12 || RUN !== 1'b0) begin
            $display("FAIL lap_pause: got q=%h run=%b want 12/0", Q, RUN); miscompares++;
        end
        LAP = 1'b1;
        step();
        LAP = 1'b0;
        vectors++;
        if (LAPQ !== 8'h12 || LAP_VALID !== 1'b1) begin
            $display("FAIL lap_capture: got lapq=%h valid=%b want 12/1", LAPQ, LAP_VALID); miscompares++;
        end
        step();
        vectors++;
        if (LAPQ !== 8'h12 || LAP_VALID !== 1'b0) begin
            $display("FAIL lap_pulse: got lapq=%h valid=%b want 12/0", LAPQ, LAP_VALID); miscompares++;
        end
        ALARM_SET = 8'h3A;
        ALARM_LD = 1'b1;
        step();
        ALARM_LD = 1'b0;
        vectors++;
        if (ERR !== 1'b1) begin
            $display("FAIL err_pulse: got %b want 1", ERR); miscompares++;
        end
        step();
        vectors++;
        if (ERR !== 1'b0) begin
            $display("FAIL err_one_cycle: got %b want 0", ERR); miscompares++;
        end
        START = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i < 20 && Q !== 8'h14; i++) begin
            step();
            if (ALARM === 1'b1 && Q !== 8'h14) begin
                vectors++;
                $display("FAIL alarm_wrong_value: got %h want 14", Q); miscompares++;
            end
        end
        vectors++;
        if (Q !== 8'h14 || ALARM !== 1'b1) begin
            $display("FAIL alarm_kept: got q=%h alarm=%b want 14/1", Q, ALARM); miscompares++;
        end
    endtask

    task automatic test_clear_combo();
        CLEAR = 1'b1;
        START = 1'b1;
        LAP = 1'b1;
        step();
        CLEAR = 1'b0;
        START = 1'b0;
        LAP = 1'b0;
        vectors++;
        if (RUN !== 1'b0 || Q !== 8'h00 || LAPQ !== 8'h00 || LAP_VALID !== 1'b0) begin
            $display("FAIL clear_combo: got run=%b q=%h lapq=%h valid=%b want 0/00/00/0",
                     RUN, Q, LAPQ, LAP_VALID);
            miscompares++;
        end
        LAP = 1'b1;
        step();
        LAP = 1'b0;
        vectors++;
        if (LAP_VALID !== 1'b0) begin
            $display("FAIL lap_in_idle: got %b want 0", LAP_VALID); miscompares++;
        end
        repeat (4) step();
        vectors++;
        if (Q !== 8'h00) begin
            $display("FAIL idle_hold: got %h want 00", Q); miscompares++;
        end
    endtask

    task automatic test_async_reset();
        START = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i < 500 && Q !== 8'h47; i++) step();
        LAP = 1'b1;
        step();
        LAP = 1'b0;
        vectors++;
        if (Q !== 8'h47 || LAPQ !== 8'h47) begin
            $display("FAIL pre_reset: got q=%h lapq=%h want 47/47", Q, LAPQ); miscompares++;
        end
        #2;
        R = 1'b1;
        #1;
        vectors++;
        if (Q !== 8'h00 || LAPQ !== 8'h00 || {RUN, WRAP, ALARM, ERR, LAP_VALID} !== 5'b0) begin
            $display("FAIL async_reset: got q=%h lapq=%h flags=%b want 00/00/00000",
                     Q, LAPQ, {RUN, WRAP, ALARM, ERR, LAP_VALID});
            miscompares++;
        end
        #1;
        R = 1'b0;
        START = 1'b1;
        step();
        START = 1'b0;
        vectors++;
        if (RUN !== 1'b1 || Q !== 8'h00) begin
            $display("FAIL post_reset_start: got run=%b q=%h want 1/00", RUN, Q); miscompares++;
        end
        repeat (3) step();
        vectors++;
        if (Q !== 8'h00) begin
            $display("FAIL post_reset_early: got %h want 00", Q); miscompares++;
        end
        step();
        vectors++;
        if (Q !== 8'h01) begin
            $display("FAIL post_reset_tick: got %h want 01", Q); miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        R         = 1'b1;
        START     = 1'b0;
        STOP      = 1'b0;
        CLEAR     = 1'b0;
        LAP       = 1'b0;
        ALARM_LD  = 1'b0;
        ALARM_SET = 8'h00;
        test_reset();
        test_start_latency();
        test_pause_resume();
        test_wrap_alarm();
        test_lap_err();
        test_clear_combo();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
